cpu_controller: RTL and testbench

- Multicycle control FSM for the 19-bit CPU datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction, one register load per cycle.
- Register loads use load_en plus the 3-bit LOAD_SELECT code (PC/IR/A/B/C).
- Owns the memory request handshake, with a timeout, and an instruction-retired counter.

---
 rtl/cpu_controller_pkg.sv | 31 +++
 rtl/cpu_controller_if.sv | 30 +++
 rtl/cpu_controller_ctrl_decode.sv | 32 +++
 rtl/cpu_controller.sv | 68 ++++++
 tb/tb_cpu_controller.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: widths, opcodes, field positions, load codes and FSM states shared by the controller.
package cpu_controller_pkg;
    localparam int WORD_SIZE     = 19;
    localparam int OPCODE_SIZE   = 5;
    localparam int FLAG_REG_SIZE = 4;
    localparam int OP_LSB        = 14;
    localparam int DEST_LSB      = 12;
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;
    localparam logic [4:0] OP_NOP     = 5'b00000;
    localparam logic [4:0] OP_ALU_MAX = 5'b01111;
    localparam logic [4:0] OP_LD      = 5'b10000;
    localparam logic [4:0] OP_ST      = 5'b10001;
    localparam logic [4:0] OP_JMP     = 5'b10010;
    localparam logic [4:0] OP_BEQ     = 5'b10011;
    localparam logic [4:0] OP_BNE     = 5'b10100;
    localparam logic [4:0] OP_HLT     = 5'b11111;
    localparam logic [1:0] DEST_A       = 2'b00;
    localparam logic [1:0] DEST_B       = 2'b01;
    localparam logic [1:0] DEST_ILLEGAL = 2'b11;
    localparam logic [2:0] SEL_PC    = 3'b000;
    localparam logic [2:0] SEL_IR    = 3'b001;
    localparam logic [2:0] SEL_REG_A = 3'b010;
    localparam logic [2:0] SEL_REG_B = 3'b011;
    localparam logic [2:0] SEL_REG_C = 3'b100;
    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD_IR, DECODE, EXEC, MEM, WB, PC_INC, JUMP, HALT
    } ctrl_state_t;
endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: datapath/memory signals between the controller (master) and the datapath (slave).
interface cpu_controller_if;
    import cpu_controller_pkg::*;
    logic [WORD_SIZE-1:0]     ir;
    logic [FLAG_REG_SIZE-1:0] flags;
    logic                     mem_ready;
    logic                     mem_req;
    logic                     mem_we;
    logic                     addr_sel;
    logic                     load_en;
    logic [2:0]               load_select;
    logic                     pc_src;
    logic [3:0]               alu_op;
    logic                     flag_load;
    logic                     instr_retired;
    logic [31:0]              instr_count;
    logic                     halted;
    logic                     illegal_op;
    logic                     bus_error;
    modport master (
        input  ir, flags, mem_ready,
        output mem_req, mem_we, addr_sel, load_en, load_select, pc_src, alu_op, flag_load,
               instr_retired, instr_count, halted, illegal_op, bus_error
    );
    modport slave (
        output ir, flags, mem_ready,
        input  mem_req, mem_we, addr_sel, load_en, load_select, pc_src, alu_op, flag_load,
               instr_retired, instr_count, halted, illegal_op, bus_error
    );
endinterface

// File: rtl/cpu_controller_ctrl_decode.sv
// ctrl_decode: classifies opcode/dest into instruction kinds; dest=11 makes register-writing ops illegal.
module ctrl_decode
    import cpu_controller_pkg::*;
(
    input  logic [OPCODE_SIZE-1:0] op,
    input  logic [1:0]             dest,
    input  logic                   z,
    output logic                   is_alu,
    output logic                   is_ld,
    output logic                   is_st,
    output logic                   is_jmp,
    output logic                   is_br,
    output logic                   br_taken,
    output logic                   is_hlt,
    output logic                   illegal,
    output logic [2:0]             dest_sel
);
    logic alu_code, ld_code, bad_dest, known;
    assign alu_code = op != OP_NOP && op <= OP_ALU_MAX;
    assign ld_code  = op == OP_LD;
    assign bad_dest = (alu_code || ld_code) && dest == DEST_ILLEGAL;
    assign known    = op == OP_NOP || alu_code || (op >= OP_LD && op <= OP_BNE) || op == OP_HLT;
    assign illegal  = !known || bad_dest;
    assign is_alu   = alu_code && !bad_dest;
    assign is_ld    = ld_code && !bad_dest;
    assign is_st    = op == OP_ST;
    assign is_jmp   = op == OP_JMP;
    assign is_br    = op == OP_BEQ || op == OP_BNE;
    assign br_taken = (op == OP_BEQ && z) || (op == OP_BNE && !z);
    assign is_hlt   = op == OP_HLT;
    assign dest_sel = dest == DEST_A ? SEL_REG_A : dest == DEST_B ? SEL_REG_B : SEL_REG_C;
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: multicycle fetch/decode/execute/memory/writeback FSM with memory timeout and retire counter.
module cpu_controller
    import cpu_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    cpu_controller_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 2);
    ctrl_state_t state;
    logic [CW-1:0] wait_cnt;
    logic [31:0] instr_count;
    logic hlt_retire, bus_err, waiting, timeout, retired;
    logic is_alu, is_ld, is_st, is_jmp, is_br, br_taken, is_hlt, illegal;
    logic [2:0] dest_sel;
    ctrl_decode u_dec (
        .op(bus.ir[OP_LSB +: OPCODE_SIZE]), .dest(bus.ir[DEST_LSB +: 2]), .z(bus.flags[FLAG_Z]),
        .is_alu(is_alu), .is_ld(is_ld), .is_st(is_st), .is_jmp(is_jmp), .is_br(is_br),
        .br_taken(br_taken), .is_hlt(is_hlt), .illegal(illegal), .dest_sel(dest_sel)
    );
    assign waiting = state == FETCH || state == MEM;
    // A ready arriving on the last allowed cycle beats the timeout
    assign timeout = MEM_TIMEOUT > 0 && waiting && !bus.mem_ready && wait_cnt == CW'(MEM_TIMEOUT - 1);
    assign retired = state == PC_INC || state == JUMP || hlt_retire;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            hlt_retire  <= 1'b0;
            bus_err     <= 1'b0;
            instr_count <= '0;
        end else begin
            wait_cnt    <= waiting && !bus.mem_ready ? wait_cnt + 1'b1 : '0;
            hlt_retire  <= state == DECODE && is_hlt;
            instr_count <= instr_count + 32'(retired);
            if (timeout) bus_err <= 1'b1;
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   state <= bus.mem_ready ? LOAD_IR : timeout ? HALT : FETCH;
                LOAD_IR: state <= DECODE;
                DECODE:  state <= is_hlt ? HALT : is_alu ? EXEC : (is_ld || is_st) ? MEM :
                                  (is_jmp || (is_br && br_taken)) ? JUMP : PC_INC;
                EXEC:    state <= WB;
                MEM:     state <= bus.mem_ready ? (is_ld ? WB : PC_INC) : timeout ? HALT : MEM;
                WB:      state <= PC_INC;
                PC_INC:  state <= FETCH;
                JUMP:    state <= FETCH;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.mem_req       = waiting;
    assign bus.mem_we        = state == MEM && is_st;
    assign bus.addr_sel      = state == MEM;
    assign bus.load_en       = state == LOAD_IR || state == WB || state == PC_INC || state == JUMP;
    assign bus.load_select   = state == LOAD_IR ? SEL_IR : state == WB ? dest_sel : SEL_PC;
    assign bus.pc_src        = state == JUMP;
    assign bus.alu_op        = state == EXEC ? bus.ir[OP_LSB +: 4] : 4'd0;
    assign bus.flag_load     = state == EXEC;
    assign bus.instr_retired = retired;
    assign bus.instr_count   = instr_count;
    assign bus.halted        = state == HALT;
    assign bus.illegal_op    = state == DECODE && illegal;
    assign bus.bus_error     = bus_err;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: randomized instruction stream with a per-instruction scoreboard, plus reset/timeout/halt cases.
module tb_cpu_controller;
    typedef struct packed {
        int          cyc;
        int          fcyc;
        int          mcyc;
        int          wecyc;
        int          nload;
        int          nflag;
        logic [14:0] lseq;
        logic [3:0]  alu;
        logic        pc_src;
        logic        ill;
        logic        halt;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0, n_ret = 0, n_iss = 0;
    rec_t sb[$];
    rec_t o, e_m;
    bit act_on = 1'b0;
    logic [16:0] outs;

    cpu_controller_if bus();
    cpu_controller #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign outs = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.load_en, bus.load_select, bus.pc_src,
                   bus.alu_op, bus.flag_load, bus.instr_retired, bus.halted, bus.illegal_op, bus.bus_error};

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Expected per-instruction behaviour from the instruction set rules and the memory waits chosen
    function automatic rec_t model(logic [4:0] op, logic [1:0] dest, logic [3:0] fl, int fw, int mw);
        rec_t e;
        bit alu, jump, known, ill;
        alu   = op >= 1 && op <= 15;
        jump  = op == 18 || (op == 19 && fl[2]) || (op == 20 && !fl[2]);
        known = op == 0 || alu || (op >= 16 && op <= 20) || op == 31;
        ill   = !known || ((alu || op == 16) && dest == 2'b11);
        e = '0;
        e.fcyc  = fw + 1;
        e.ill   = ill;
        e.cyc   = fw + 4;
        e.nload = 2;
        e.lseq  = 15'({3'd1, 3'd0});
        if (!ill && op == 31) begin
            e.nload = 1;
            e.lseq  = 15'd1;
            e.halt  = 1'b1;
        end else if (!ill && alu) begin
            e.cyc   = fw + 6;
            e.nload = 3;
            e.lseq  = 15'({3'd1, 3'(2 + dest), 3'd0});
            e.alu   = op[3:0];
            e.nflag = 1;
        end else if (!ill && op == 16) begin
            e.cyc   = fw + mw + 6;
            e.nload = 3;
            e.lseq  = 15'({3'd1, 3'(2 + dest), 3'd0});
            e.mcyc  = mw + 1;
        end else if (!ill && op == 17) begin
            e.cyc   = fw + mw + 5;
            e.mcyc  = mw + 1;
            e.wecyc = mw + 1;
        end else begin
            e.pc_src = jump && !ill;
        end
        return e;
    endfunction

    // Monitor: accumulates what the DUT does over one instruction and scores it at the retire pulse
    initial forever begin
        @(negedge clk);
        if (rst) begin
            act_on = 1'b0;
            n_ret  = 0;
        end else begin
            if (!act_on && bus.mem_req && !bus.addr_sel) begin
                act_on = 1'b1;
                o = '0;
            end
            if (act_on) begin
                o.cyc = o.cyc + 1;
                if (bus.load_en) begin
                    o.lseq  = {o.lseq[11:0], bus.load_select};
                    o.nload = o.nload + 1;
                end
                if (bus.flag_load) begin
                    o.nflag = o.nflag + 1;
                    o.alu   = bus.alu_op;
                end
                if (bus.illegal_op) o.ill = 1'b1;
                if (bus.mem_req && !bus.addr_sel) o.fcyc = o.fcyc + 1;
                if (bus.mem_req && bus.addr_sel) begin
                    o.mcyc = o.mcyc + 1;
                    if (bus.mem_we) o.wecyc = o.wecyc + 1;
                end
                if (bus.instr_retired) begin
                    o.pc_src = bus.pc_src;
                    o.halt   = bus.halted;
                    chk("instr_count", bus.instr_count, n_ret);
                    n_ret++;
                    if (sb.size() == 0) chk("unexpected_retire", sb.size(), 1);
                    else begin
                        e_m = sb.pop_front();
                        chk("latency", o.cyc, e_m.cyc);
                        chk("fetch_cycles", o.fcyc, e_m.fcyc);
                        chk("mem_cycles", o.mcyc, e_m.mcyc);
                        chk("store_we_cycles", o.wecyc, e_m.wecyc);
                        chk("load_count", o.nload, e_m.nload);
                        chk("load_sequence", o.lseq, e_m.lseq);
                        chk("flag_loads", o.nflag, e_m.nflag);
                        chk("alu_op", o.alu, e_m.alu);
                        chk("pc_src", o.pc_src, e_m.pc_src);
                        chk("illegal_op", o.ill, e_m.ill);
                        chk("halted_on_retire", o.halt, e_m.halt);
                    end
                    act_on = 1'b0;
                end
            end
        end
    end

    task automatic run_instr(input logic [4:0] op, input logic [1:0] dest, input logic [3:0] fl,
                             input int fw, input int mw);
        int g, rc;
        g = 0;
        while (!(bus.mem_req && !bus.addr_sel) && g < 20) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            g++;
        end
        if (g == 20) begin
            chk("fetch_start_timeout", g, 0);
            return;
        end
        bus.ir    = {op, dest, 12'($urandom)};
        bus.flags = fl;
        sb.push_back(model(op, dest, fl, fw, mw));
        n_iss++;
        rc = 0;
        for (g = 0; g < 40; g++) begin
            if (bus.mem_req) begin
                bus.mem_ready = rc == (bus.addr_sel ? mw : fw);
                rc++;
            end else begin
                bus.mem_ready = 1'($urandom);
                rc = 0;
            end
            if (bus.instr_retired) break;
            @(negedge clk);
        end
        if (g == 40) chk("retire_timeout", g, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, m, n, bad;
        bus.ir = '0;
        bus.flags = '0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 0);
        chk("reset_count", bus.instr_count, 0);
        rst = 1'b0;
        run_instr(5'b00011, 2'b01, 4'b0000, 0, 0);
        run_instr(5'b10000, 2'b10, 4'b0000, 0, 3);
        run_instr(5'b10011, 2'b00, 4'b0100, 0, 0);
        run_instr(5'b10011, 2'b00, 4'b0000, 0, 0);
        run_instr(5'b10100, 2'b00, 4'b0100, 0, 0);
        run_instr(5'b10100, 2'b00, 4'b0000, 0, 0);
        run_instr(5'b11000, 2'b00, 4'b0000, 0, 0);
        run_instr(5'b00101, 2'b11, 4'b0000, 0, 0);
        run_instr(5'b10001, 2'b01, 4'b1111, 3, 1);
        run_instr(5'b10010, 2'b10, 4'b0000, 2, 0);
        run_instr(5'b00000, 2'b00, 4'b0000, 3, 0);
        for (int i = 0; i < 200; i++)
            run_instr(5'($urandom_range(0, 30)), 2'($urandom), 4'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        // Reset in the middle of a store's memory phase
        g = 0;
        while (!(bus.mem_req && !bus.addr_sel) && g < 20) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
            g++;
        end
        chk("count_after_stream", bus.instr_count, n_iss);
        chk("scoreboard_drained", sb.size(), 0);
        bus.ir = {5'b10001, 2'b00, 12'h0};
        m = 0;
        for (g = 0; g < 20; g++) begin
            if (bus.mem_req && bus.addr_sel) m++;
            if (m == 3) break;
            bus.mem_ready = bus.mem_req && !bus.addr_sel;
            @(negedge clk);
        end
        chk("reached_mid_mem", m, 3);
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_mem_rst_mem_req", bus.mem_req, 0);
        chk("mid_mem_rst_count", bus.instr_count, 0);
        chk("mid_mem_rst_outputs", outs, 0);
        rst = 1'b0;
        n_iss = 0;
        // Fetch that never completes
        g = 0;
        while (!bus.mem_req && g < 20) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            g++;
        end
        n = 0;
        while (bus.mem_req && n < 20) begin
            bus.mem_ready = 1'b0;
            n++;
            @(negedge clk);
        end
        chk("timeout_wait_cycles", n, 4);
        chk("timeout_bus_error", bus.bus_error, 1);
        chk("timeout_halted", bus.halted, 1);
        chk("timeout_mem_req", bus.mem_req, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            if (!bus.halted || bus.mem_req || !bus.bus_error || bus.instr_retired || bus.load_en) bad++;
        end
        chk("error_halt_absorbing", bad, 0);
        chk("error_no_retire", bus.instr_count, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_clears_error", outs, 0);
        rst = 1'b0;
        // HLT then hold
        run_instr(5'b11111, 2'($urandom), 4'($urandom), 1, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            if (!bus.halted || bus.mem_req || bus.instr_retired || bus.bus_error || bus.load_en) bad++;
        end
        chk("hlt_holds", bad, 0);
        chk("hlt_count", bus.instr_count, 1);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
